// File: rtl/sdram_defs.sv
// Shared definitions for the SDRAM init responder: command codes, stage encodings,
// violation codes and the sampled control-bus payload.
package sdram_defs;

  localparam int unsigned CMD_W     = 3;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned BANK_W    = 2;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned GAP_W     = 4;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned A10_BIT   = 10;
  localparam int unsigned A8_BIT    = 8;

  localparam logic [CMD_W-1:0] CMD_MRST = 3'b000;
  localparam logic [CMD_W-1:0] CMD_ARSR = 3'b001;
  localparam logic [CMD_W-1:0] CMD_PRCH = 3'b010;
  localparam logic [CMD_W-1:0] CMD_ACTV = 3'b011;
  localparam logic [CMD_W-1:0] CMD_WRIT = 3'b100;
  localparam logic [CMD_W-1:0] CMD_READ = 3'b101;
  localparam logic [CMD_W-1:0] CMD_BTRM = 3'b110;
  localparam logic [CMD_W-1:0] CMD_NOOP = 3'b111;

  localparam logic [CODE_W-1:0] ERR_NONE     = 4'd0;
  localparam logic [CODE_W-1:0] ERR_CKE_LOW  = 4'd1;
  localparam logic [CODE_W-1:0] ERR_ORDER    = 4'd2;
  localparam logic [CODE_W-1:0] ERR_GAP      = 4'd3;
  localparam logic [CODE_W-1:0] ERR_OPERAND  = 4'd4;
  localparam logic [CODE_W-1:0] ERR_CLOSED   = 4'd5;
  localparam logic [CODE_W-1:0] ERR_OPEN     = 4'd6;
  localparam logic [CODE_W-1:0] ERR_CKE_RUN  = 4'd7;

  typedef enum logic [3:0] {
    S_PWR  = 4'd0,
    S_PRE1 = 4'd1,
    S_EMRS = 4'd2,
    S_MRS1 = 4'd3,
    S_PRE2 = 4'd4,
    S_REF1 = 4'd5,
    S_REF2 = 4'd6,
    S_MRS2 = 4'd7,
    S_RUN  = 4'd8
  } stage_e;

  typedef struct packed {
    logic              cke;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
  } cmd_bus_t;

  function automatic logic is_noop(input logic [CMD_W-1:0] c);
    return c == CMD_NOOP;
  endfunction

endpackage

// File: rtl/sdram_init_responder_if.sv
// SDRAM control-bus pins as seen by the device: controller drives, responder samples.
interface sdram_init_responder_if;
  import sdram_defs::*;

  logic              CKE;
  logic [CMD_W-1:0]  COMMAND_PIN;
  logic [ADDR_W-1:0] ADDRESS_PIN;
  logic [BANK_W-1:0] BANK_PIN;

  modport master (output CKE, COMMAND_PIN, ADDRESS_PIN, BANK_PIN);
  modport slave  (input  CKE, COMMAND_PIN, ADDRESS_PIN, BANK_PIN);
endinterface

// File: rtl/sdram_bank_tracker.sv
// Per-bank row-open tracking with closed-bank access and double-activate checks.
module sdram_bank_tracker
  import sdram_defs::*;
(
  input  logic                 CLK_n,
  input  logic                 RST,
  input  logic                 en,
  input  logic [CMD_W-1:0]     cmd,
  input  logic [BANK_W-1:0]    bank,
  input  logic                 a10,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [CODE_W-1:0]    code_c
);

  logic [NUM_BANKS-1:0] open_q;
  logic [NUM_BANKS-1:0] open_nxt;

  always_ff @(posedge CLK_n) begin
    if (!RST) open_q <= '0;
    else      open_q <= open_nxt;
  end

  // An errored ACTV leaves the bank state as it was.
  always_comb begin
    open_nxt = open_q;
    code_c   = ERR_NONE;
    if (en) begin
      case (cmd)
        CMD_ACTV: begin
          if (open_q[bank]) code_c = ERR_OPEN;
          else              open_nxt[bank] = 1'b1;
        end
        CMD_READ, CMD_WRIT: begin
          if (!open_q[bank]) code_c = ERR_CLOSED;
        end
        CMD_PRCH: begin
          if (a10) open_nxt = '0;
          else     open_nxt[bank] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bank_open = open_q;

endmodule

// File: rtl/sdram_init_responder.sv
// Device-side SDRAM bus responder: decodes the power-up sequence, tracks mode registers
// and open banks, enforces command spacing and latches the first protocol violation.
module sdram_init_responder
  import sdram_defs::*;
#(
  parameter int unsigned MIN_GAP = 2
) (
  input  logic                  CLK_n,
  input  logic                  RST,
  sdram_init_responder_if.slave bus,
  output logic                  INIT_DONE,
  output logic [ADDR_W-1:0]     MODE_REG,
  output logic [ADDR_W-1:0]     EXT_MODE_REG,
  output logic [2:0]            CAS_LATENCY,
  output logic [2:0]            BURST_LEN,
  output logic [NUM_BANKS-1:0]  BANK_OPEN,
  output logic                  ERR,
  output logic [CODE_W-1:0]     ERR_CODE
);

  cmd_bus_t pin_c;
  assign pin_c = '{cke: bus.CKE, cmd: bus.COMMAND_PIN, addr: bus.ADDRESS_PIN, bank: bus.BANK_PIN};

  stage_e              stage_q, stage_nxt;
  logic [GAP_W-1:0]    gap_q, gap_nxt;
  logic [ADDR_W-1:0]   mode_q, mode_nxt;
  logic [ADDR_W-1:0]   ext_q, ext_nxt;
  logic                done_q, done_nxt;
  logic                err_q, err_nxt;
  logic [CODE_W-1:0]   code_q, code_nxt;
  logic [CODE_W-1:0]   viol_c;
  logic [CODE_W-1:0]   trk_code_c;
  logic [NUM_BANKS-1:0] bank_open;
  logic                is_cmd_c;
  logic                gap_bad_c;
  logic                trk_en_c;
  logic                a10_c;
  logic                a8_c;

  assign is_cmd_c  = !is_noop(pin_c.cmd);
  assign gap_bad_c = is_cmd_c && (gap_q < GAP_W'(MIN_GAP));
  assign a10_c     = pin_c.addr[A10_BIT];
  assign a8_c      = pin_c.addr[A8_BIT];
  assign trk_en_c  = (stage_q == S_RUN) && pin_c.cke &&
                     ((pin_c.cmd == CMD_ACTV) || (pin_c.cmd == CMD_READ) ||
                      (pin_c.cmd == CMD_WRIT) || (pin_c.cmd == CMD_PRCH));

  sdram_bank_tracker u_bank_tracker (
    .CLK_n     (CLK_n),
    .RST       (RST),
    .en        (trk_en_c),
    .cmd       (pin_c.cmd),
    .bank      (pin_c.bank),
    .a10       (a10_c),
    .bank_open (bank_open),
    .code_c    (trk_code_c)
  );

  always_ff @(posedge CLK_n) begin
    if (!RST) begin
      stage_q <= S_PWR;
      gap_q   <= '1;
      mode_q  <= '0;
      ext_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      stage_q <= stage_nxt;
      gap_q   <= gap_nxt;
      mode_q  <= mode_nxt;
      ext_q   <= ext_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      code_q  <= code_nxt;
    end
  end

  // Stage sequencing, register capture and violation priority.
  always_comb begin
    stage_nxt = stage_q;
    gap_nxt   = gap_q;
    mode_nxt  = mode_q;
    ext_nxt   = ext_q;
    done_nxt  = done_q;
    err_nxt   = err_q;
    code_nxt  = code_q;
    viol_c    = ERR_NONE;

    if (is_cmd_c)          gap_nxt = '0;
    else if (gap_q != '1)  gap_nxt = gap_q + GAP_W'(1);

    case (stage_q)
      S_PWR: begin
        if (!pin_c.cke) begin
          if (is_cmd_c) viol_c = ERR_CKE_LOW;
        end else begin
          stage_nxt = S_PRE1;
        end
      end
      S_PRE1, S_PRE2: begin
        if (is_cmd_c) begin
          if (pin_c.cmd != CMD_PRCH) viol_c = ERR_ORDER;
          else if (!a10_c)           viol_c = ERR_OPERAND;
          else                       stage_nxt = (stage_q == S_PRE1) ? S_EMRS : S_REF1;
        end
      end
      S_EMRS: begin
        if (is_cmd_c) begin
          if (pin_c.cmd != CMD_MRST)     viol_c = ERR_ORDER;
          else if (pin_c.bank != 2'd1)   viol_c = ERR_OPERAND;
          else begin
            ext_nxt   = pin_c.addr;
            stage_nxt = S_MRS1;
          end
        end
      end
      S_MRS1, S_MRS2: begin
        if (is_cmd_c) begin
          if (pin_c.cmd != CMD_MRST) viol_c = ERR_ORDER;
          else if ((pin_c.bank != 2'd0) || (a8_c != (stage_q == S_MRS1))) viol_c = ERR_OPERAND;
          else begin
            mode_nxt = pin_c.addr;
            if (stage_q == S_MRS1) begin
              stage_nxt = S_PRE2;
            end else begin
              done_nxt  = 1'b1;
              stage_nxt = S_RUN;
            end
          end
        end
      end
      S_REF1, S_REF2: begin
        if (is_cmd_c) begin
          if (pin_c.cmd != CMD_ARSR) viol_c = ERR_ORDER;
          else                       stage_nxt = (stage_q == S_REF1) ? S_REF2 : S_MRS2;
        end
      end
      S_RUN: begin
        if (!pin_c.cke) begin
          viol_c = ERR_CKE_RUN;
        end else if (is_cmd_c) begin
          case (pin_c.cmd)
            CMD_ARSR: if (|bank_open) viol_c = ERR_ORDER;
            CMD_MRST: begin
              if (pin_c.bank == 2'd0)      mode_nxt = pin_c.addr;
              else if (pin_c.bank == 2'd1) ext_nxt  = pin_c.addr;
            end
            default:  viol_c = trk_code_c;
          endcase
        end
      end
      default: stage_nxt = S_PWR;
    endcase

    if ((viol_c == ERR_NONE) && gap_bad_c) viol_c = ERR_GAP;

    if (!err_q && (viol_c != ERR_NONE)) begin
      err_nxt  = 1'b1;
      code_nxt = viol_c;
    end
  end

  assign INIT_DONE    = done_q;
  assign MODE_REG     = mode_q;
  assign EXT_MODE_REG = ext_q;
  assign CAS_LATENCY  = mode_q[6:4];
  assign BURST_LEN    = mode_q[2:0];
  assign BANK_OPEN    = bank_open;
  assign ERR          = err_q;
  assign ERR_CODE     = code_q;

endmodule

// File: tb/tb_sdram_init_responder.sv
// Scoreboard bench for sdram_init_responder: expected outputs are queued per command and
// compared one cycle later.
module tb_sdram_init_responder;
  import sdram_defs::*;

  typedef struct {
    string       tag;
    logic        done;
    logic [12:0] mode;
    logic [12:0] ext;
    logic [3:0]  bo;
    logic        err;
    logic [3:0]  code;
  } exp_t;

  logic        CLK_n = 1'b0;
  logic        RST;
  logic        INIT_DONE;
  logic [12:0] MODE_REG;
  logic [12:0] EXT_MODE_REG;
  logic [2:0]  CAS_LATENCY;
  logic [2:0]  BURST_LEN;
  logic [3:0]  BANK_OPEN;
  logic        ERR;
  logic [3:0]  ERR_CODE;

  sdram_init_responder_if bus();

  sdram_init_responder #(.MIN_GAP(2)) dut (
    .CLK_n        (CLK_n),
    .RST          (RST),
    .bus          (bus),
    .INIT_DONE    (INIT_DONE),
    .MODE_REG     (MODE_REG),
    .EXT_MODE_REG (EXT_MODE_REG),
    .CAS_LATENCY  (CAS_LATENCY),
    .BURST_LEN    (BURST_LEN),
    .BANK_OPEN    (BANK_OPEN),
    .ERR          (ERR),
    .ERR_CODE     (ERR_CODE)
  );

  always #5 CLK_n = ~CLK_n;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic        e_done;
  logic [12:0] e_mode, e_ext;
  logic [3:0]  e_bo;
  logic        e_err;
  logic [3:0]  e_code;

  logic [2:0]  init_cmd  [7];
  logic [12:0] init_addr [7];
  logic [1:0]  init_bank [7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.done = e_done; e.mode = e_mode; e.ext = e_ext;
    e.bo = e_bo; e.err = e_err; e.code = e_code;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    @(posedge CLK_n);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".done"}, 32'(INIT_DONE),    32'(e.done));
      check({e.tag, ".mode"}, 32'(MODE_REG),     32'(e.mode));
      check({e.tag, ".ext"},  32'(EXT_MODE_REG), 32'(e.ext));
      check({e.tag, ".cas"},  32'(CAS_LATENCY),  32'(e.mode[6:4]));
      check({e.tag, ".bl"},   32'(BURST_LEN),    32'(e.mode[2:0]));
      check({e.tag, ".bo"},   32'(BANK_OPEN),    32'(e.bo));
      check({e.tag, ".err"},  32'(ERR),          32'(e.err));
      check({e.tag, ".code"}, 32'(ERR_CODE),     32'(e.code));
    end
  endtask

  task automatic drive(input logic cke, input logic [2:0] cmd, input logic [12:0] addr,
                       input logic [1:0] bank);
    @(negedge CLK_n);
    bus.CKE = cke; bus.COMMAND_PIN = cmd; bus.ADDRESS_PIN = addr; bus.BANK_PIN = bank;
  endtask

  task automatic step(input logic cke, input logic [2:0] cmd, input logic [12:0] addr,
                      input logic [1:0] bank, input string tag);
    drive(cke, cmd, addr, bank);
    push_exp(tag);
    pop_compare();
  endtask

  task automatic noops(input int n, input logic cke);
    repeat (n) drive(cke, CMD_NOOP, 13'h000, 2'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK_n);
    RST = 1'b0;
    bus.CKE = 1'b0; bus.COMMAND_PIN = CMD_NOOP; bus.ADDRESS_PIN = '0; bus.BANK_PIN = '0;
    e_done = 1'b0; e_mode = '0; e_ext = '0; e_bo = '0; e_err = 1'b0; e_code = '0;
    push_exp(tag);
    pop_compare();
    @(negedge CLK_n);
    RST = 1'b1;
  endtask

  task automatic run_init(input int first, input int last, input int lead, input string tag);
    for (int i = first; i <= last; i++) begin
      noops((i == first) ? lead : 15, 1'b1);
      if (i == 1) e_ext = init_addr[i];
      if (i == 2 || i == 6) e_mode = init_addr[i];
      if (i == 6) e_done = 1'b1;
      step(1'b1, init_cmd[i], init_addr[i], init_bank[i], $sformatf("%s.i%0d", tag, i));
    end
  endtask

  task automatic cke_up(input string tag);
    step(1'b1, CMD_NOOP, 13'h000, 2'd0, tag);
  endtask

  task automatic run_cmd(input logic [2:0] cmd, input logic [12:0] addr, input logic [1:0] bank,
                         input string tag);
    noops(3, 1'b1);
    step(1'b1, cmd, addr, bank, tag);
  endtask

  initial begin
    init_cmd[0] = CMD_PRCH; init_addr[0] = 13'h400; init_bank[0] = 2'd0;
    init_cmd[1] = CMD_MRST; init_addr[1] = 13'h000; init_bank[1] = 2'd1;
    init_cmd[2] = CMD_MRST; init_addr[2] = 13'h161; init_bank[2] = 2'd0;
    init_cmd[3] = CMD_PRCH; init_addr[3] = 13'h400; init_bank[3] = 2'd0;
    init_cmd[4] = CMD_ARSR; init_addr[4] = 13'h000; init_bank[4] = 2'd0;
    init_cmd[5] = CMD_ARSR; init_addr[5] = 13'h000; init_bank[5] = 2'd0;
    init_cmd[6] = CMD_MRST; init_addr[6] = 13'h031; init_bank[6] = 2'd0;
    RST = 1'b0;
    bus.CKE = 1'b0; bus.COMMAND_PIN = CMD_NOOP; bus.ADDRESS_PIN = '0; bus.BANK_PIN = '0;

    // Clean power-up after a long CKE-low hold.
    do_reset("t1.rst");
    noops(256, 1'b0);
    cke_up("t1.cke");
    run_init(0, 6, 15, "t1");

    // Out-of-order command in S_PRE1, then a back-to-back gap violation.
    do_reset("t2.rst");
    cke_up("t2.cke");
    noops(15, 1'b1);
    e_err = 1'b1; e_code = ERR_ORDER;
    step(1'b1, CMD_ARSR, 13'h000, 2'd0, "t2.arsr");
    run_init(0, 6, 0, "t2");

    // Gap violation on an otherwise valid EMRS; stage must still advance.
    do_reset("t3.rst");
    cke_up("t3.cke");
    noops(15, 1'b1);
    step(1'b1, CMD_PRCH, 13'h400, 2'd0, "t3.prch");
    noops(1, 1'b1);
    e_err = 1'b1; e_code = ERR_GAP; e_ext = 13'h000;
    step(1'b1, CMD_MRST, 13'h000, 2'd1, "t3.emrs");
    run_init(2, 6, 15, "t3");

    // Bank tracking in S_RUN.
    do_reset("t4.rst");
    cke_up("t4.cke");
    run_init(0, 6, 15, "t4");
    e_bo = 4'b0001; run_cmd(CMD_ACTV, 13'h055, 2'd0, "t4.actv0");
    e_bo = 4'b1001; run_cmd(CMD_ACTV, 13'h0AA, 2'd3, "t4.actv3");
    e_bo = 4'b0000; run_cmd(CMD_PRCH, 13'h400, 2'd0, "t4.prall");
    e_mode = 13'h022; run_cmd(CMD_MRST, 13'h022, 2'd0, "t4.mrs");
    e_bo = 4'b0100; run_cmd(CMD_ACTV, 13'h123, 2'd2, "t4.actv2");
    run_cmd(CMD_READ, 13'h010, 2'd2, "t4.rd2");
    e_bo = 4'b0000; run_cmd(CMD_PRCH, 13'h000, 2'd2, "t4.pr2");
    e_err = 1'b1; e_code = ERR_CLOSED;
    run_cmd(CMD_READ, 13'h010, 2'd2, "t4.rdcl");

    do_reset("t4b.rst");
    cke_up("t4b.cke");
    run_init(0, 6, 15, "t4b");
    e_bo = 4'b0010; run_cmd(CMD_ACTV, 13'h001, 2'd1, "t4b.actv1");
    e_err = 1'b1; e_code = ERR_OPEN;
    run_cmd(CMD_ACTV, 13'h002, 2'd1, "t4b.actv1x");

    // CKE-low command, mid-sequence reset, then a clean run.
    do_reset("t5.rst");
    e_err = 1'b1; e_code = ERR_CKE_LOW;
    step(1'b0, CMD_ARSR, 13'h000, 2'd0, "t5.ckelow");
    do_reset("t5.rst2");
    cke_up("t5.cke");
    run_init(0, 2, 15, "t5a");
    do_reset("t5.rstmid");
    noops(4, 1'b0);
    cke_up("t5.cke2");
    run_init(0, 6, 15, "t5b");

    // CKE drop after init.
    noops(3, 1'b1);
    e_err = 1'b1; e_code = ERR_CKE_RUN;
    step(1'b0, CMD_NOOP, 13'h000, 2'd0, "t6.ckedrop");
    noops(3, 1'b0);
    step(1'b0, CMD_ACTV, 13'h000, 2'd0, "t6.actv_lowcke");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
